// File: rtl/serial2parallel_rx_pkg.sv
// rtl/serial2parallel_rx_pkg.sv - shared state type and default word width for the serial link
package serial2parallel_rx_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

endpackage

// File: rtl/serial2parallel_rx_if.sv
// rtl/serial2parallel_rx_if.sv - serial link input and deserialized word/status outputs
interface serial2parallel_rx_if #(
  parameter int WIDTH = serial2parallel_rx_pkg::DEFAULT_WIDTH
);

  logic             din;
  logic             frame_in;
  logic [WIDTH-1:0] dout;
  logic             valid_out;
  logic             locked;
  logic             frame_err;

  modport master (
    output din,
    output frame_in,
    input  dout,
    input  valid_out,
    input  locked,
    input  frame_err
  );

  modport slave (
    input  din,
    input  frame_in,
    output dout,
    output valid_out,
    output locked,
    output frame_err
  );

endinterface

// File: rtl/serial2parallel_rx.sv
// rtl/serial2parallel_rx.sv - MSB-first deserializer with frame alignment tracking
module serial2parallel_rx
  import serial2parallel_rx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial2parallel_rx_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  rx_state_t        state;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             locked_q;
  logic             err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      shift_q  <= '0;
      cnt      <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bus.frame_in) begin
        // A frame marker always restarts the word; mid-word it also flags truncation
        if (state == SHIFT && cnt != '0) begin
          err_q    <= 1'b1;
          locked_q <= 1'b0;
        end
        shift_q <= WIDTH'(bus.din);
        cnt     <= CW'(1);
        state   <= SHIFT;
      end else if (state == SHIFT) begin
        if (cnt == '0) begin
          err_q    <= 1'b1;
          locked_q <= 1'b0;
          state    <= HUNT;
        end else if (cnt == CW'(WIDTH - 1)) begin
          dout_q   <= {shift_q[WIDTH-2:0], bus.din};
          shift_q  <= {shift_q[WIDTH-2:0], bus.din};
          valid_q  <= 1'b1;
          locked_q <= 1'b1;
          cnt      <= '0;
        end else begin
          shift_q <= {shift_q[WIDTH-2:0], bus.din};
          cnt     <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid_out = valid_q;
  assign bus.locked    = locked_q;
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_serial2parallel_rx.sv
// tb/tb_serial2parallel_rx.sv - self-checking bench for serial2parallel_rx with a history-based reference model
module tb_serial2parallel_rx;
  import serial2parallel_rx_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial2parallel_rx_if #(.WIDTH(W)) bus();

  serial2parallel_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;

  // Reference model: outputs are derived from the stimulus history since reset,
  // using the distance from each cycle back to the most recent frame marker.
  bit hf[$];
  bit hd[$];
  logic [W-1:0] exp_dout;
  logic exp_valid, exp_locked, exp_err;

  task automatic model_reset();
    hf.delete();
    hd.delete();
    exp_dout   = '0;
    exp_valid  = 1'b0;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
  endtask

  function automatic int last_frame(int upto);
    for (int i = upto; i >= 0; i--)
      if (hf[i]) return i;
    return -1;
  endfunction

  task automatic model_cycle(bit f, bit d);
    int n, l, p;
    hf.push_back(f);
    hd.push_back(d);
    n = hf.size() - 1;
    l = last_frame(n);
    exp_valid = (l >= 0) && (l == n - (W - 1));
    exp_err = 1'b0;
    if (f) begin
      p = last_frame(n - 1);
      if (p >= 0 && (n - p) < W) exp_err = 1'b1;
    end else if (l >= 0 && (n - l) == W) begin
      exp_err = 1'b1;
    end
    if (exp_valid) begin
      for (int i = 0; i < W; i++) exp_dout[W-1-i] = hd[l+i];
      exp_locked = 1'b1;
    end
    if (exp_err) exp_locked = 1'b0;
  endtask

  task automatic drive(bit f, bit d);
    @(negedge clk);
    bus.frame_in = f;
    bus.din      = d;
    @(posedge clk);
    #1;
    model_cycle(f, d);
  endtask

  task automatic test_reset();
    bus.frame_in = 1'b0;
    bus.din      = 1'b0;
    rst_n        = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {1'b0, 1'b0, 1'b0, 4'h0}) begin
      mismatched++;
      $display("FAIL reset: got v=%b e=%b l=%b d=%h want all zero",
               bus.valid_out, bus.frame_err, bus.locked, bus.dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    w = 4'hB;
    for (int b = 0; b < W; b++) begin
      drive(b == 0, w[W-1-b]);
      compared++;
      if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {exp_valid, exp_err, exp_locked, exp_dout}) begin
        mismatched++;
        $display("FAIL single b%0d: got v=%b e=%b l=%b d=%h want v=%b e=%b l=%b d=%h", b,
                 bus.valid_out, bus.frame_err, bus.locked, bus.dout, exp_valid, exp_err, exp_locked, exp_dout);
      end
    end
    compared++;
    if ({bus.valid_out, bus.locked, bus.frame_err, bus.dout} !== {1'b1, 1'b1, 1'b0, 4'hB}) begin
      mismatched++;
      $display("FAIL single_word: got v=%b l=%b e=%b d=%h want v=1 l=1 e=0 d=b",
               bus.valid_out, bus.locked, bus.frame_err, bus.dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    words = '{4'hB, 4'h6, 4'hF};
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < W; b++) begin
        drive(b == 0, words[k][W-1-b]);
        compared++;
        if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {exp_valid, exp_err, exp_locked, exp_dout}) begin
          mismatched++;
          $display("FAIL b2b w%0d b%0d: got v=%b e=%b l=%b d=%h want v=%b e=%b l=%b d=%h", k, b,
                   bus.valid_out, bus.frame_err, bus.locked, bus.dout, exp_valid, exp_err, exp_locked, exp_dout);
        end
      end
      compared++;
      if ({bus.valid_out, bus.locked, bus.dout} !== {1'b1, 1'b1, words[k]}) begin
        mismatched++;
        $display("FAIL b2b_word%0d: got v=%b l=%b d=%h want v=1 l=1 d=%h", k,
                 bus.valid_out, bus.locked, bus.dout, words[k]);
      end
    end
  endtask

  task automatic test_missed_frame();
    int errs;
    logic [W-1:0] held;
    errs = 0;
    held = bus.dout;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, c[0]);
      errs += int'(bus.frame_err);
      compared++;
      if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {exp_valid, exp_err, exp_locked, exp_dout}) begin
        mismatched++;
        $display("FAIL missed c%0d: got v=%b e=%b l=%b d=%h want v=%b e=%b l=%b d=%h", c,
                 bus.valid_out, bus.frame_err, bus.locked, bus.dout, exp_valid, exp_err, exp_locked, exp_dout);
      end
    end
    compared++;
    if (errs !== 1 || bus.locked !== 1'b0 || bus.dout !== held) begin
      mismatched++;
      $display("FAIL missed_summary: got errs=%0d l=%b d=%h want errs=1 l=0 d=%h",
               errs, bus.locked, bus.dout, held);
    end
  endtask

  task automatic test_early_frame();
    bit f [7];
    bit d [7];
    f = '{1, 0, 1, 0, 0, 0, 0};
    d = '{0, 1, 1, 0, 0, 1, 0};
    for (int c = 0; c < 7; c++) begin
      drive(f[c], d[c]);
      compared++;
      if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {exp_valid, exp_err, exp_locked, exp_dout}) begin
        mismatched++;
        $display("FAIL early c%0d: got v=%b e=%b l=%b d=%h want v=%b e=%b l=%b d=%h", c,
                 bus.valid_out, bus.frame_err, bus.locked, bus.dout, exp_valid, exp_err, exp_locked, exp_dout);
      end
      if (c == 2) begin
        compared++;
        if ({bus.frame_err, bus.locked} !== 2'b10) begin
          mismatched++;
          $display("FAIL early_err: got e=%b l=%b want e=1 l=0", bus.frame_err, bus.locked);
        end
      end
      if (c == 5) begin
        compared++;
        if ({bus.valid_out, bus.dout} !== {1'b1, 4'h9}) begin
          mismatched++;
          $display("FAIL early_word: got v=%b d=%h want v=1 d=9", bus.valid_out, bus.dout);
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compared++;
    if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {1'b0, 1'b0, 1'b0, 4'h0}) begin
      mismatched++;
      $display("FAIL reset_mid: got v=%b e=%b l=%b d=%h want all zero",
               bus.valid_out, bus.frame_err, bus.locked, bus.dout);
    end
    bus.frame_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, ~c[0]);
      compared++;
      if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {1'b0, 1'b0, 1'b0, 4'h0}) begin
        mismatched++;
        $display("FAIL reset_idle c%0d: got v=%b e=%b l=%b d=%h want all zero", c,
                 bus.valid_out, bus.frame_err, bus.locked, bus.dout);
      end
    end
  endtask

  task automatic test_loopback();
    logic [W-1:0] tx_word;
    int hits;
    tx_word = 4'hA;
    hits = 0;
    for (int c = 0; c < 6 * W; c++) begin
      drive((c % W) == 0, tx_word[W-1-(c % W)]);
      if ((c % W) == W - 1) hits += int'(bus.valid_out && bus.dout == 4'hA && bus.locked);
      compared++;
      if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {exp_valid, exp_err, exp_locked, exp_dout}) begin
        mismatched++;
        $display("FAIL loopback c%0d: got v=%b e=%b l=%b d=%h want v=%b e=%b l=%b d=%h", c,
                 bus.valid_out, bus.frame_err, bus.locked, bus.dout, exp_valid, exp_err, exp_locked, exp_dout);
      end
    end
    compared++;
    if (hits !== 6) begin
      mismatched++;
      $display("FAIL loopback_words: got %0d good words want 6", hits);
    end
  endtask

  task automatic test_random();
    int phase;
    bit f;
    phase = 0;
    for (int c = 0; c < 600; c++) begin
      if (c < 300) begin
        f = ($urandom_range(0, 3) == 0);
      end else begin
        // mostly aligned traffic with occasional slips and drops
        f = (phase == 0);
        if ($urandom_range(0, 15) == 0) f = ~f;
        phase = (phase + 1) % W;
      end
      drive(f, 1'($urandom()));
      compared++;
      if ({bus.valid_out, bus.frame_err, bus.locked, bus.dout} !== {exp_valid, exp_err, exp_locked, exp_dout}) begin
        mismatched++;
        $display("FAIL random c%0d: got v=%b e=%b l=%b d=%h want v=%b e=%b l=%b d=%h", c,
                 bus.valid_out, bus.frame_err, bus.locked, bus.dout, exp_valid, exp_err, exp_locked, exp_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_missed_frame();
    test_early_frame();
    test_reset_mid_word();
    test_loopback();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
